// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl
//   Frame sequencer for an external combinational 8-point FFT core.
//   It collects 8 real samples over a valid/ready stream, holds them on
//   core_f, lets the core settle for CORE_LAT+1 cycles, captures the
//   8 complex bins and streams them out one bin per handshake.
//
//   Handshake rule (both streams): a transfer happens on a rising clock
//   edge where valid && ready are both high. Valid never depends on ready.
//
//   Ports
//     clk, rst_n                   clock, asynchronous active-low reset
//     in_valid/in_ready            sample stream handshake
//     in_data [N-1:0]              signed sample
//     in_last                      marks the 8th sample of a frame
//     core_f  [8*N-1:0]            {f_7..f_0} to the core
//     core_re/core_im [8*(N+1)-1:0] {F_7..F_0} from the core
//     out_valid/out_ready          bin stream handshake
//     out_re/out_im [N:0]          signed bin value
//     out_idx [2:0]                true bin index k
//     out_last                     final bin of the frame
//     busy                         high in SETTLE and UNLOAD
//     frame_err                    one-cycle pulse after a framing error
//     state_dbg [1:0]              current FSM state (LOAD=0, SETTLE=1, UNLOAD=2)
//
//   Configuration macro FFT8_BITREV_OUT_EN: when defined, bins leave in
//   bit-reversed order (0,4,2,6,1,5,3,7); otherwise in natural order.
module fft8_frame_ctrl #(
  parameter int N        = 8,
  parameter int CORE_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic                 in_last,
  output logic [8*N-1:0]       core_f,
  input  logic [8*(N+1)-1:0]   core_re,
  input  logic [8*(N+1)-1:0]   core_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N:0]           out_re,
  output logic [N:0]           out_im,
  output logic [2:0]           out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 frame_err,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {LOAD = 2'd0, SETTLE = 2'd1, UNLOAD = 2'd2} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(CORE_LAT);

  state_t     state, state_nx;
  logic [2:0] wr_idx, rd_idx, ord;
  logic [3:0] settle_cnt;
  logic [N-1:0] sample [8];
  logic [N:0]   res_re [8];
  logic [N:0]   res_im [8];

  logic in_fire, out_fire, bad_frame, good_end, settle_done;

  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  // An accepted sample is a framing error whenever in_last disagrees with
  // "this is the 8th slot".
  assign bad_frame   = in_fire && (in_last != (wr_idx == 3'd7));
  assign good_end    = in_fire && in_last && (wr_idx == 3'd7);
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign state_dbg   = state;

`ifdef FFT8_BITREV_OUT_EN
  assign ord = {rd_idx[0], rd_idx[1], rd_idx[2]};
`else
  assign ord = rd_idx;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  // Next state and stream controls
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (good_end) state_nx = SETTLE;
      end
      SETTLE: begin
        if (settle_done) state_nx = UNLOAD;
      end
      UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready && (rd_idx == 3'd7)) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      settle_cnt <= '0;
      frame_err  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        sample[i] <= '0;
        res_re[i] <= '0;
        res_im[i] <= '0;
      end
    end else begin
      frame_err <= bad_frame;
      if (in_fire) begin
        sample[wr_idx] <= in_data;
        // Both a good end and an error restart the frame at slot 0.
        wr_idx <= (bad_frame || good_end) ? 3'd0 : wr_idx + 3'd1;
      end
      if (state == SETTLE) begin
        settle_cnt <= settle_done ? 4'd0 : settle_cnt + 4'd1;
        if (settle_done) begin
          for (int i = 0; i < 8; i++) begin
            res_re[i] <= core_re[i*(N+1) +: (N+1)];
            res_im[i] <= core_im[i*(N+1) +: (N+1)];
          end
        end
      end else begin
        settle_cnt <= '0;
      end
      // 3-bit wrap returns rd_idx to 0 after the 8th bin.
      if (out_fire) rd_idx <= rd_idx + 3'd1;
    end
  end

  always_comb begin
    core_f = '0;
    for (int i = 0; i < 8; i++) core_f[i*N +: N] = sample[i];
  end

  assign out_re   = res_re[ord];
  assign out_im   = res_im[ord];
  assign out_idx  = ord;
  assign out_last = out_valid && (rd_idx == 3'd7);

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
module tb_fft8_frame_ctrl;
  localparam int N   = 8;
  localparam int LAT = 3;
  localparam int W   = 3 + 1 + 2 * (N + 1);

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [N-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy, frame_err;
  logic [8*N-1:0] core_f;
  logic [8*(N+1)-1:0] core_re, core_im;
  logic [N:0] out_re, out_im;
  logic [2:0] out_idx;
  logic [1:0] state_dbg;

  int n_tests = 0, n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur;
  assign cur = {out_idx, out_last, out_re, out_im};

  // Clock / reset
  always #5 clk = ~clk;

  fft8_frame_ctrl #(.N(N), .CORE_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_f(core_f), .core_re(core_re), .core_im(core_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .frame_err(frame_err), .state_dbg(state_dbg)
  );

  // Reference DFT: X[k] = sum x[n] * exp(-j*2*pi*k*n/8), twiddles scaled by 256
  function automatic int cos256(input int m);
    case (m)
      0: return 256; 1: return 181; 2: return 0;    3: return -181;
      4: return -256; 5: return -181; 6: return 0;  default: return 181;
    endcase
  endfunction

  function automatic int sin256(input int m);
    case (m)
      0: return 0;  1: return 181;  2: return 256;  3: return 181;
      4: return 0;  5: return -181; 6: return -256; default: return -181;
    endcase
  endfunction

  function automatic logic [N:0] dft(input logic [8*N-1:0] f, input int k, input bit want_im);
    int acc;
    int r;
    logic signed [N-1:0] x;
    acc = 0;
    for (int n = 0; n < 8; n++) begin
      x = f[n*N +: N];
      acc += int'(x) * (want_im ? -sin256((k * n) % 8) : cos256((k * n) % 8));
    end
    r = (acc + 128) >>> 8;
    return r[N:0];
  endfunction

  function automatic int bitrev3(input int p);
    return ((p % 2) * 4) + (((p / 2) % 2) * 2) + ((p / 4) % 2);
  endfunction

  // Combinational core model driven from the controller's core_f
  always_comb begin
    core_re = '0;
    core_im = '0;
    for (int k = 0; k < 8; k++) begin
      core_re[k*(N+1) +: (N+1)] = dft(core_f, k, 1'b0);
      core_im[k*(N+1) +: (N+1)] = dft(core_f, k, 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Driver: one sample, waits (bounded) for in_ready, returns #1 after the edge
  task automatic push(input logic [N-1:0] d, input bit last, input bit expect_err);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_timeout", 64'(t < 100), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("frame_err", 64'(frame_err), 64'(expect_err));
    if (expect_err) begin
      @(posedge clk); #1;
      chk("frame_err_pulse_end", 64'(frame_err), 64'd0);
    end
  endtask

  task automatic idle_check(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
    end
  endtask

  // Scoreboard consumer
  task automatic drain(input int bp_at, input bit rand_bp);
    int got, guard, cyc;
    logic [W-1:0] hold;
    got = 0; guard = 0;
    while (got < 8 && guard < 300) begin
      guard++;
      if (!out_valid) begin
        out_ready = 1'b0;
        @(posedge clk); #1;
        continue;
      end
      cyc = 0;
      if (got == bp_at) begin
        cyc = 4;
        bp_at = -1;
      end else if (rand_bp && $urandom_range(0, 3) == 0) begin
        cyc = $urandom_range(1, 3);
      end
      if (cyc > 0) begin
        out_ready = 1'b0;
        hold = cur;
        repeat (cyc) begin
          @(posedge clk); #1;
          chk("bp_valid", 64'(out_valid), 64'd1);
          chk("bp_hold", 64'(cur), 64'(hold));
        end
      end
      out_ready = 1'b1;
      chk("exp_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("bin", 64'(cur), 64'(exp_q.pop_front()));
      chk("in_ready_unload", 64'(in_ready), 64'd0);
      chk("busy_unload", 64'(busy), 64'd1);
      got++;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    chk("bins_per_frame", 64'(got), 64'd8);
    chk("in_ready_after_unload", 64'(in_ready), 64'd1);
    chk("out_valid_after_unload", 64'(out_valid), 64'd0);
    chk("busy_after_unload", 64'(busy), 64'd0);
  endtask

  task automatic run_frame(input logic [8*N-1:0] f, input int bp_at, input bit rand_bp);
    int lat, k;
    logic [2:0] kk;
    logic lst;
    for (int p = 0; p < 8; p++) begin
`ifdef FFT8_BITREV_OUT_EN
      k = bitrev3(p);
`else
      k = p;
`endif
      kk = k[2:0];
      lst = (p == 7);
      exp_q.push_back({kk, lst, dft(f, k, 1'b0), dft(f, k, 1'b1)});
    end
    for (int n = 0; n < 8; n++) push(f[n*N +: N], n == 7, 1'b0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      chk("in_ready_settle", 64'(in_ready), 64'd0);
      chk("busy_settle", 64'(busy), 64'd1);
      chk("core_f_settle", 64'(core_f), 64'(f));
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(LAT + 1));
    drain(bp_at, rand_bp);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_frame(output logic [8*N-1:0] f);
    logic [N-1:0] s;
    f = '0;
    for (int n = 0; n < 8; n++) begin
      s = N'($urandom_range(0, 30)) - N'(15);
      f[n*N +: N] = s;
    end
  endtask

  initial begin : stim
    logic [8*N-1:0] f;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_core_f", 64'(core_f), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_bin", 64'(cur), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Reset mid-frame after 3 samples
    push(N'(7), 1'b0, 1'b0);
    push(N'(9), 1'b0, 1'b0);
    push(N'(11), 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_core_f", 64'(core_f), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    // 5 more samples ending with in_last: only an error if the old frame was dropped
    for (int n = 0; n < 4; n++) push(N'(1), 1'b0, 1'b0);
    push(N'(1), 1'b1, 1'b1);
    idle_check(LAT + 4);

    // Impulse at f_0
    f = '0; f[N-1:0] = N'(1);
    run_frame(f, -1, 1'b0);

    // DC frame with 4-cycle back-pressure at the third emitted bin
    f = '0;
    for (int n = 0; n < 8; n++) f[n*N +: N] = N'(5);
    run_frame(f, 2, 1'b0);

    // in_last on the 5th sample
    for (int n = 0; n < 4; n++) push(N'($urandom_range(0, 20)), 1'b0, 1'b0);
    push(N'(3), 1'b1, 1'b1);
    idle_check(LAT + 4);
    rand_frame(f);
    run_frame(f, -1, 1'b0);

    // 8th sample without in_last
    for (int n = 0; n < 8; n++) push(N'($urandom_range(0, 20)), 1'b0, n == 7);
    idle_check(LAT + 4);
    rand_frame(f);
    run_frame(f, -1, 1'b0);

    // Impulse at f_1
    f = '0; f[N +: N] = N'(1);
    run_frame(f, 5, 1'b0);

    // Random frames with random back-pressure
    for (int r = 0; r < 6; r++) begin
      rand_frame(f);
      run_frame(f, -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
